// File: rtl/mprj_seq_monitor.sv
// Checkpoint sequence monitor: watches a synchronised probe bus step through a
// programmed list of masked values, with per-step timeout and abort.
module mprj_seq_monitor #(
  parameter int WIDTH       = 16,
  parameter int STEPS       = 8,
  parameter int ALTS        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 2,
  parameter int TMR_W       = 24
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic [WIDTH-1:0]           probe,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(STEPS+1)-1:0] num_steps,
  input  logic [TMR_W-1:0]           timeout_limit,
  input  logic                       cfg_we,
  input  logic [$clog2(STEPS)-1:0]   cfg_step,
  input  logic [$clog2(ALTS)-1:0]    cfg_alt,
  input  logic                       cfg_en,
  input  logic [WIDTH-1:0]           cfg_value,
  input  logic [WIDTH-1:0]           cfg_mask,
  output logic                       cfg_nack,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [$clog2(STEPS+1)-1:0] cur_step,
  output logic                       step_pulse,
  output logic [$clog2(ALTS)-1:0]    match_alt
);

  localparam int SW = $clog2(STEPS+1);
  localparam int IW = $clog2(STEPS);
  localparam int AW = $clog2(ALTS);
  localparam int CW = $clog2(STABLE+1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     cur_nxt, nsteps_r, nsteps_nxt, num_clamped;
  logic [TMR_W-1:0]  timer, timer_nxt, limit_r, limit_nxt;
  logic [CW-1:0]     stable_cnt, stable_nxt;
  logic [1:0]        code_nxt;
  logic              pulse_nxt;
  logic [AW-1:0]     alt_nxt, hit_alt;
  logic              hit, accept, cfg_ok;
  logic [IW-1:0]     cur_idx;
  logic [WIDTH-1:0]  probe_s;

  logic              tbl_en    [STEPS][ALTS];
  logic [WIDTH-1:0]  tbl_value [STEPS][ALTS];
  logic [WIDTH-1:0]  tbl_mask  [STEPS][ALTS];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign probe_s = probe;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= probe;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign probe_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // The table is only writable while no sequence is being checked.
  assign cfg_ok = (state != ST_RUN) && (int'(cfg_step) < STEPS) && (int'(cfg_alt) < ALTS);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int s = 0; s < STEPS; s++) begin
        for (int a = 0; a < ALTS; a++) begin
          tbl_en[s][a]    <= 1'b0;
          tbl_value[s][a] <= '0;
          tbl_mask[s][a]  <= '0;
        end
      end
      cfg_nack <= 1'b0;
    end else begin
      cfg_nack <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        tbl_en[cfg_step][cfg_alt]    <= cfg_en;
        tbl_value[cfg_step][cfg_alt] <= cfg_value;
        tbl_mask[cfg_step][cfg_alt]  <= cfg_mask;
      end
    end
  end

  assign cur_idx = IW'(cur_step);

  // Scan downwards so the lowest-numbered hitting alternative wins.
  always_comb begin
    hit     = 1'b0;
    hit_alt = '0;
    for (int a = ALTS-1; a >= 0; a--) begin
      if (tbl_en[cur_idx][a] &&
          (((probe_s ^ tbl_value[cur_idx][a]) & tbl_mask[cur_idx][a]) == '0)) begin
        hit     = 1'b1;
        hit_alt = AW'(a);
      end
    end
  end

  assign num_clamped = (int'(num_steps) > STEPS) ? SW'(STEPS) : num_steps;

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur_step;
    timer_nxt  = timer;
    stable_nxt = stable_cnt;
    code_nxt   = fail_code;
    pulse_nxt  = 1'b0;
    alt_nxt    = match_alt;
    nsteps_nxt = nsteps_r;
    limit_nxt  = limit_r;
    accept     = hit && (stable_cnt == CW'(STABLE-1));
    case (state)
      ST_RUN: begin
        // Priority: abort, then acceptance, then timeout.
        if (abort) begin
          state_nxt = ST_FAIL;
          code_nxt  = 2'b10;
        end else if (accept) begin
          pulse_nxt  = 1'b1;
          alt_nxt    = hit_alt;
          timer_nxt  = '0;
          stable_nxt = '0;
          cur_nxt    = cur_step + SW'(1);
          if (cur_step + SW'(1) == nsteps_r) state_nxt = ST_PASS;
        end else begin
          timer_nxt  = (timer == {TMR_W{1'b1}}) ? timer : timer + TMR_W'(1);
          stable_nxt = hit ? stable_cnt + CW'(1) : '0;
          if ((limit_r != '0) && (timer == limit_r - TMR_W'(1))) begin
            state_nxt = ST_FAIL;
            code_nxt  = 2'b01;
          end
        end
      end
      default: begin
        if (start) begin
          cur_nxt    = '0;
          timer_nxt  = '0;
          stable_nxt = '0;
          code_nxt   = 2'b00;
          nsteps_nxt = num_clamped;
          limit_nxt  = timeout_limit;
          state_nxt  = (num_clamped == '0) ? ST_PASS : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      cur_step   <= '0;
      timer      <= '0;
      stable_cnt <= '0;
      fail_code  <= 2'b00;
      step_pulse <= 1'b0;
      match_alt  <= '0;
      nsteps_r   <= '0;
      limit_r    <= '0;
    end else begin
      state      <= state_nxt;
      cur_step   <= cur_nxt;
      timer      <= timer_nxt;
      stable_cnt <= stable_nxt;
      fail_code  <= code_nxt;
      step_pulse <= pulse_nxt;
      match_alt  <= alt_nxt;
      nsteps_r   <= nsteps_nxt;
      limit_r    <= limit_nxt;
    end
  end

  assign busy = (state == ST_RUN);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_mprj_seq_monitor.sv
// Self-checking bench for mprj_seq_monitor: vector table, directed corner
// sequences and randomized traffic against a timing-level reference model.
module tb_mprj_seq_monitor;

  localparam int WIDTH  = 16;
  localparam int STEPS  = 8;
  localparam int ALTS   = 3;
  localparam int SYNC   = 2;
  localparam int STABLE = 2;
  localparam int TMR_W  = 24;

  logic              clock = 1'b0;
  logic              resetb = 1'b1;
  logic [WIDTH-1:0]  probe = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        num_steps = '0;
  logic [TMR_W-1:0]  timeout_limit = '0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_step = '0;
  logic [1:0]        cfg_alt = '0;
  logic              cfg_en = 1'b0;
  logic [WIDTH-1:0]  cfg_value = '0;
  logic [WIDTH-1:0]  cfg_mask = '0;
  logic              cfg_nack, busy, pass, fail, step_pulse;
  logic [1:0]        fail_code, match_alt;
  logic [3:0]        cur_step;

  always #5 clock = ~clock;

  mprj_seq_monitor #(
    .WIDTH(WIDTH), .STEPS(STEPS), .ALTS(ALTS),
    .SYNC_STAGES(SYNC), .STABLE(STABLE), .TMR_W(TMR_W)
  ) dut (
    .clock(clock), .resetb(resetb), .probe(probe), .start(start), .abort(abort),
    .num_steps(num_steps), .timeout_limit(timeout_limit), .cfg_we(cfg_we),
    .cfg_step(cfg_step), .cfg_alt(cfg_alt), .cfg_en(cfg_en), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_nack(cfg_nack), .busy(busy), .pass(pass), .fail(fail),
    .fail_code(fail_code), .cur_step(cur_step), .step_pulse(step_pulse),
    .match_alt(match_alt)
  );

  typedef struct {
    logic        en;
    logic [15:0] value;
    logic [15:0] mask;
  } entry_t;

  typedef struct {
    logic [15:0] value;
    logic [15:0] mask;
    logic [15:0] probe;
    logic        exp_pass;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;

  // Reference model: a step is accepted once the last STABLE synchronised samples
  // all hit it and they were all taken after the step began; timeout fires
  // timeout_limit edges after the step began.
  entry_t      mtab [STEPS][ALTS];
  mstate_t     m_state;
  int          m_step, m_code, m_alt, m_nsteps, m_limit, run_start, edge_n;
  logic        m_pulse, m_nack;
  logic [15:0] pin_hist [$];

  int tests = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < STEPS; s++)
      for (int a = 0; a < ALTS; a++) mtab[s][a] = '{1'b0, 16'h0, 16'h0};
    m_state = M_IDLE; m_step = 0; m_code = 0; m_alt = 0; m_nsteps = 0; m_limit = 0;
    m_pulse = 1'b0; m_nack = 1'b0; run_start = edge_n;
    pin_hist = {};
    repeat (8) pin_hist.push_back(16'h0);
  endtask

  function automatic logic m_hit(input int s, input logic [15:0] p, output int alt);
    alt = 0;
    for (int a = 0; a < ALTS; a++) begin
      if (mtab[s][a].en && (((p ^ mtab[s][a].value) & mtab[s][a].mask) == 16'h0)) begin
        alt = a;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic modelEdge();
    int   alt, dummy;
    logic acc;
    pin_hist.push_front(probe);
    void'(pin_hist.pop_back());
    edge_n++;
    m_pulse = 1'b0;
    m_nack  = cfg_we && !(m_state != M_RUN && int'(cfg_step) < STEPS && int'(cfg_alt) < ALTS);
    if (m_state == M_RUN) begin
      acc = (edge_n - run_start >= STABLE);
      for (int j = 0; j < STABLE; j++)
        if (!m_hit(m_step, pin_hist[SYNC+j], dummy)) acc = 1'b0;
      if (abort) begin
        m_state = M_FAIL; m_code = 2;
      end else if (acc) begin
        void'(m_hit(m_step, pin_hist[SYNC], alt));
        m_alt = alt; m_pulse = 1'b1; m_step++; run_start = edge_n;
        if (m_step == m_nsteps) m_state = M_PASS;
      end else if (m_limit != 0 && edge_n - run_start == m_limit) begin
        m_state = M_FAIL; m_code = 1;
      end
    end else if (start) begin
      m_nsteps  = (int'(num_steps) > STEPS) ? STEPS : int'(num_steps);
      m_limit   = int'(timeout_limit);
      m_step    = 0; m_code = 0; run_start = edge_n;
      m_state   = (m_nsteps == 0) ? M_PASS : M_RUN;
    end
    if (cfg_we && !m_nack) mtab[cfg_step][cfg_alt] = '{cfg_en, cfg_value, cfg_mask};
  endtask

  task automatic checkOutput();
    logic [12:0] gotv, expv;
    gotv = {busy, pass, fail, fail_code, cur_step, step_pulse, match_alt, cfg_nack};
    expv = {m_state == M_RUN, m_state == M_PASS, m_state == M_FAIL, 2'(m_code),
            4'(m_step), m_pulse, 2'(m_alt), m_nack};
    check("outputs{busy,pass,fail,code,step,pulse,alt,nack}", 32'(gotv), 32'(expv));
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [15:0] p, input logic st, input logic ab);
    probe = p; start = st; abort = ab;
    cycle();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic cfgWrite(input int s, input int a, input logic en,
                          input logic [15:0] v, input logic [15:0] m);
    cfg_we = 1'b1; cfg_step = 3'(s); cfg_alt = 2'(a); cfg_en = en;
    cfg_value = v; cfg_mask = m;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic doReset();
    resetb = 1'b0;
    #2;
    check("reset outputs zero",
          32'({busy, pass, fail, fail_code, cur_step, step_pulse, match_alt, cfg_nack}), 32'h0);
    @(posedge clock);
    #1;
    resetb = 1'b1;
    modelReset();
  endtask

  vec_t        vecs [7];
  logic [15:0] seq1 [3];
  logic [15:0] pool [4];
  logic [15:0] masks [4];

  initial begin
    int pulses, alt1, acc_c, fail_c, hold;
    logic [15:0] cur_p;

    vecs[0] = '{16'h000A, 16'h000F, 16'h123A, 1'b1};
    vecs[1] = '{16'h000A, 16'h000F, 16'h123B, 1'b0};
    vecs[2] = '{16'hAB40, 16'hFFFF, 16'hAB40, 1'b1};
    vecs[3] = '{16'hAB40, 16'hFFFF, 16'hAB41, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 16'hBEEF, 1'b1};
    vecs[5] = '{16'hF0F0, 16'hF0F0, 16'hF5F5, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 16'h7FFF, 1'b0};
    seq1  = '{16'hAB40, 16'h198B, 16'hAB51};
    pool  = '{16'h1111, 16'h2222, 16'h1221, 16'h2112};
    masks = '{16'hFFFF, 16'h00FF, 16'hF00F, 16'h000F};
    edge_n = 0;

    #1;
    doReset();

    // Single-step masked match table.
    for (int i = 0; i < 7; i++) begin
      cfgWrite(0, 0, 1'b1, vecs[i].value, vecs[i].mask);
      num_steps = 4'd1; timeout_limit = 24'd20;
      repeat (3) applyStimulus(vecs[i].probe, 1'b0, 1'b0);
      applyStimulus(vecs[i].probe, 1'b1, 1'b0);
      repeat (4) applyStimulus(vecs[i].probe, 1'b0, 1'b0);
      check($sformatf("vec%0d pass", i), 32'(pass), 32'(vecs[i].exp_pass));
      repeat (20) applyStimulus(vecs[i].probe, 1'b0, 1'b0);
      check($sformatf("vec%0d final {pass,fail,code}", i), 32'({pass, fail, fail_code}),
            vecs[i].exp_pass ? 32'h8 : 32'h5);
    end

    // Three-step sequence with an alternative-matched middle step.
    doReset();
    cfgWrite(0, 0, 1'b1, 16'hAB40, 16'hFFFF);
    cfgWrite(1, 0, 1'b1, 16'h1968, 16'hFFFF);
    cfgWrite(1, 1, 1'b1, 16'h1969, 16'hFFFF);
    cfgWrite(1, 2, 1'b1, 16'h198B, 16'hFFFF);
    cfgWrite(2, 0, 1'b1, 16'hAB51, 16'hFFFF);
    num_steps = 4'd3; timeout_limit = 24'd1000;
    pulses = 0; alt1 = -1;
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    for (int v = 0; v < 3; v++) begin
      repeat (10) begin
        applyStimulus(seq1[v], 1'b0, 1'b0);
        if (step_pulse) begin
          pulses++;
          if (cur_step == 4'd2) alt1 = int'(match_alt);
        end
      end
    end
    check("t1 step pulses", 32'(pulses), 32'd3);
    check("t1 alt at step1", 32'(alt1), 32'd2);
    check("t1 pass", 32'(pass), 32'd1);
    check("t1 cur_step", 32'(cur_step), 32'd3);

    // Stuck probe: timeout exactly timeout_limit cycles after step 0.
    acc_c = 0; fail_c = 0;
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    for (int c = 1; c <= 1100; c++) begin
      applyStimulus(16'hAB40, 1'b0, 1'b0);
      if (step_pulse) acc_c = c;
      if (fail) begin
        fail_c = c;
        break;
      end
    end
    check("t2 fail", 32'(fail), 32'd1);
    check("t2 fail_code", 32'(fail_code), 32'd1);
    check("t2 cur_step", 32'(cur_step), 32'd1);
    check("t2 cycles to timeout", 32'(fail_c - acc_c), 32'd1000);

    // One-sample glitch must not be accepted; a held value must.
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    repeat (4) applyStimulus(16'hAB40, 1'b0, 1'b0);
    pulses = 0;
    applyStimulus(16'h1968, 1'b0, 1'b0);
    pulses += int'(step_pulse);
    repeat (5) begin
      applyStimulus(16'hAB40, 1'b0, 1'b0);
      pulses += int'(step_pulse);
    end
    check("t3 glitch pulses", 32'(pulses), 32'd0);
    pulses = 0;
    repeat (6) begin
      applyStimulus(16'h1968, 1'b0, 1'b0);
      pulses += int'(step_pulse);
    end
    check("t3 held pulses", 32'(pulses), 32'd1);
    check("t3 cur_step", 32'(cur_step), 32'd2);
    check("t3 match_alt", 32'(match_alt), 32'd0);
    applyStimulus(16'h1968, 1'b0, 1'b1);

    // Abort on the same edge that would accept step 1.
    repeat (3) applyStimulus(16'hAB40, 1'b0, 1'b0);
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    repeat (2) applyStimulus(16'hAB40, 1'b0, 1'b0);
    repeat (3) applyStimulus(16'h198B, 1'b0, 1'b0);
    applyStimulus(16'h198B, 1'b0, 1'b1);
    check("t5 fail", 32'(fail), 32'd1);
    check("t5 fail_code", 32'(fail_code), 32'd2);
    check("t5 cur_step", 32'(cur_step), 32'd1);

    cfgWrite(0, 3, 1'b1, 16'h0, 16'h0);
    check("t5 nack alt out of range", 32'(cfg_nack), 32'd1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    cfgWrite(0, 0, 1'b1, 16'h0000, 16'h0000);
    check("t5 nack while busy", 32'(cfg_nack), 32'd1);
    repeat (6) applyStimulus(16'h0000, 1'b0, 1'b0);
    check("t5 table unchanged", 32'({busy, cur_step}), 32'h10);
    applyStimulus(16'h0000, 1'b0, 1'b1);

    // Empty sequence passes immediately; reset mid-run clears everything.
    num_steps = 4'd0;
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    check("t6 zero-step pass", 32'({busy, pass, cur_step}), 32'h10);
    num_steps = 4'd3;
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    repeat (3) applyStimulus(16'hAB40, 1'b0, 1'b0);
    doReset();
    num_steps = 4'd1; timeout_limit = '0;
    applyStimulus(16'hAB40, 1'b1, 1'b0);
    repeat (6) applyStimulus(16'hAB40, 1'b0, 1'b0);
    check("t6 table disabled after reset", 32'({busy, cur_step}), 32'h10);
    applyStimulus(16'hAB40, 1'b0, 1'b1);

    // Randomized traffic, including ignored start/config while running.
    cur_p = pool[0]; hold = 0;
    for (int t = 0; t < 25; t++) begin
      repeat (6)
        cfgWrite(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), ($urandom % 3) != 0,
                 pool[$urandom % 4], masks[$urandom % 4]);
      num_steps = 4'($urandom_range(0, 10));
      timeout_limit = (($urandom % 3) == 0) ? '0 : TMR_W'($urandom_range(6, 40));
      applyStimulus(cur_p, 1'b1, 1'b0);
      for (int c = 0; c < 120 && m_state == M_RUN; c++) begin
        if (hold == 0) begin
          cur_p = (($urandom % 8) == 0) ? 16'($urandom) : pool[$urandom % 4];
          hold  = int'($urandom_range(1, 5));
        end
        hold--;
        if (($urandom % 10) == 0) num_steps = 4'($urandom);
        if (($urandom % 10) == 0) timeout_limit = TMR_W'($urandom_range(1, 5));
        cfg_we = (($urandom % 20) == 0);
        cfg_step = 3'($urandom); cfg_alt = 2'($urandom); cfg_en = 1'b1;
        cfg_value = 16'($urandom); cfg_mask = 16'h0;
        applyStimulus(cur_p, ($urandom % 25) == 0, ($urandom % 80) == 0);
        cfg_we = 1'b0;
      end
      if (m_state == M_RUN) applyStimulus(cur_p, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
